// File: rtl/cook_timer_dp.sv
// Microwave cook-time datapath: MM:SS edit via debounced up/down presses while idle,
// 1 Hz countdown while run is high, and a one-cycle finish pulse on reaching 00:00.
module cook_timer_dp #(
    parameter int TICK_DIV = 100_000_000,
    parameter int MAX_MIN  = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] btn,
    input  logic [1:0] sel,
    input  logic       run,
    output logic [5:0] min,
    output logic [5:0] sec,
    output logic       finish
);
    localparam int            PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PS_LAST  = PW'(TICK_DIV - 1);
    localparam logic [5:0]    MIN_LAST = 6'(MAX_MIN);
    localparam logic [5:0]    SEC_LAST = 6'd59;

    logic [1:0]    btn_prev;
    logic [1:0]    press;
    logic          up;
    logic          dn;
    logic [PW-1:0] presc;
    logic          tick;
    logic [5:0]    min_next;
    logic [5:0]    sec_next;
    logic          fin_next;

    // Simultaneous up and down presses cancel each other.
    assign press = btn & ~btn_prev;
    assign up    = press[1] & ~press[0];
    assign dn    = press[0] & ~press[1];
    assign tick  = run && (presc == PS_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) btn_prev <= '0;
        else     btn_prev <= btn;
    end

    // Held at zero while idle so a resumed countdown always waits a full period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)               presc <= '0;
        else if (!run || tick) presc <= '0;
        else                   presc <= presc + 1'b1;
    end

    always_comb begin
        min_next = min;
        sec_next = sec;
        fin_next = 1'b0;
        if (run) begin
            if (tick) begin
                if (sec != 6'd0) begin
                    sec_next = sec - 6'd1;
                end else if (min != 6'd0) begin
                    min_next = min - 6'd1;
                    sec_next = SEC_LAST;
                end
                // Result is 00:00 either by reaching it or by holding there.
                fin_next = (min == 6'd0) && (sec <= 6'd1);
            end
        end else begin
            case (sel)
                2'b10: begin
                    if (up)      min_next = (min == MIN_LAST) ? 6'd0 : min + 6'd1;
                    else if (dn) min_next = (min == 6'd0) ? MIN_LAST : min - 6'd1;
                end
                2'b01: begin
                    if (up)      sec_next = (sec == SEC_LAST) ? 6'd0 : sec + 6'd1;
                    else if (dn) sec_next = (sec == 6'd0) ? SEC_LAST : sec - 6'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min    <= 6'd0;
            sec    <= 6'd0;
            finish <= 1'b0;
        end else begin
            min    <= min_next;
            sec    <= sec_next;
            finish <= fin_next;
        end
    end

endmodule

// File: tb/tb_cook_timer_dp.sv
// Bench for cook_timer_dp: directed scenarios plus random traffic, checked every cycle
// against a total-seconds reference model.
module tb_cook_timer_dp;
    localparam int TD = 10;
    localparam int MM = 59;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] btn;
    logic [1:0] sel;
    logic       run;
    logic [5:0] min;
    logic [5:0] sec;
    logic       finish;

    int checks   = 0;
    int failures = 0;

    int         m_min;
    int         m_sec;
    int         m_run_cyc;
    logic [1:0] m_prev;
    logic       m_fin;

    always #5 clk = ~clk;

    cook_timer_dp #(.TICK_DIV(TD), .MAX_MIN(MM)) dut (
        .clk(clk), .rst(rst), .btn(btn), .sel(sel), .run(run),
        .min(min), .sec(sec), .finish(finish)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_min = 0; m_sec = 0; m_run_cyc = 0; m_prev = 2'b00; m_fin = 1'b0;
    endtask

    // Works on total seconds and modulo arithmetic rather than field-wise compares.
    task automatic model_clock();
        logic [1:0] rise;
        int total;
        if (rst) begin
            model_reset();
            return;
        end
        rise   = btn & ~m_prev;
        m_prev = btn;
        m_fin  = 1'b0;
        if (run) begin
            m_run_cyc++;
            if (m_run_cyc % TD == 0) begin
                total = m_min * 60 + m_sec;
                if (total > 0) total--;
                m_min = total / 60;
                m_sec = total % 60;
                m_fin = (total == 0);
            end
        end else begin
            m_run_cyc = 0;
            if (rise == 2'b10) begin
                if (sel == 2'b10)      m_min = (m_min + 1) % (MM + 1);
                else if (sel == 2'b01) m_sec = (m_sec + 1) % 60;
            end else if (rise == 2'b01) begin
                if (sel == 2'b10)      m_min = (m_min + MM) % (MM + 1);
                else if (sel == 2'b01) m_sec = (m_sec + 59) % 60;
            end
        end
    endtask

    task automatic chk_model();
        chk("model_min", min, m_min);
        chk("model_sec", sec, m_sec);
        chk("model_finish", finish, m_fin);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            model_clock();
            #1;
            chk_model();
        end
    endtask

    task automatic press(input logic [1:0] b);
        btn = b;
        step(1);
        btn = 2'b00;
        step(1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run = 1'b0;
        btn = 2'b00;
        sel = 2'b00;
        #1;
        model_reset();
        chk("rst_min", min, 0);
        chk("rst_sec", sec, 0);
        chk("rst_finish", finish, 0);
        step(1);
        rst = 1'b0;
        step(1);
    endtask

    initial begin
        rst = 1'b1; btn = 2'b00; sel = 2'b00; run = 1'b0;
        model_reset();
        step(2);
        chk("por_min", min, 0);
        chk("por_sec", sec, 0);
        chk("por_finish", finish, 0);
        rst = 1'b0;
        step(1);

        // Editing: minute ups, seconds wrap on down, held button counts once
        sel = 2'b10;
        repeat (3) press(2'b10);
        sel = 2'b01;
        press(2'b01);
        chk("t1_min", min, 3);
        chk("t1_sec_wrap", sec, 59);
        sel = 2'b10;
        btn = 2'b10;
        step(20);
        btn = 2'b00;
        step(1);
        chk("t1_hold_once", min, 4);
        sel = 2'b10;
        repeat (5) press(2'b01);
        press(2'b01);
        press(2'b10);
        press(2'b01);
        chk("t1_min_down", min, 58);
        sel = 2'b11;
        press(2'b10);
        chk("t1_sel11_ignored", min, 58);

        // Countdown from 01:01 to 00:00
        do_reset();
        sel = 2'b10; press(2'b10);
        sel = 2'b01; press(2'b10);
        sel = 2'b00;
        run = 1'b1;
        for (int c = 1; c <= 61 * TD; c++) begin
            step(1);
            if (c == TD) begin
                chk("t2_c10_min", min, 1);
                chk("t2_c10_sec", sec, 0);
            end
            if (c == 2 * TD) begin
                chk("t2_c20_min", min, 0);
                chk("t2_c20_sec", sec, 59);
            end
            if (c == 61 * TD - 1) chk("t2_pre_finish", finish, 0);
        end
        chk("t2_end_sec", sec, 0);
        chk("t2_end_finish", finish, 1);
        run = 1'b0;
        step(1);
        chk("t2_finish_one_cycle", finish, 0);

        // Pause and resume
        do_reset();
        sel = 2'b01;
        repeat (5) press(2'b10);
        sel = 2'b00;
        run = 1'b1;
        step(25);
        chk("t3_run_sec", sec, 3);
        run = 1'b0;
        step(30);
        chk("t3_pause_sec", sec, 3);
        run = 1'b1;
        step(TD - 1);
        chk("t3_resume_wait", sec, 3);
        step(1);
        chk("t3_resume_dec", sec, 2);
        run = 1'b0;
        step(1);

        // Run at 00:00 repeats finish every tick
        do_reset();
        run = 1'b1;
        for (int c = 1; c <= 3 * TD; c++) begin
            step(1);
            if (c % TD == 0) chk("t4_finish_pulse", finish, 1);
        end
        chk("t4_min", min, 0);
        chk("t4_sec", sec, 0);
        run = 1'b0;
        step(2);

        // Simultaneous up/down ignored; presses ignored while running
        do_reset();
        sel = 2'b01;
        repeat (30) press(2'b10);
        chk("t5_load", sec, 30);
        btn = 2'b11;
        step(1);
        btn = 2'b00;
        step(1);
        chk("t5_both", sec, 30);
        run = 1'b1;
        press(2'b10);
        chk("t5_run_press", sec, 30);
        run = 1'b0;
        step(1);

        // Reset mid-run at 02:17, then reset with a finish pending
        do_reset();
        sel = 2'b10;
        repeat (2) press(2'b10);
        sel = 2'b01;
        repeat (17) press(2'b10);
        sel = 2'b00;
        chk("t6_load_min", min, 2);
        chk("t6_load_sec", sec, 17);
        run = 1'b1;
        step(5);
        do_reset();
        step(20);
        sel = 2'b01;
        press(2'b10);
        sel = 2'b00;
        run = 1'b1;
        step(TD - 1);
        chk("t6_pending_sec", sec, 1);
        do_reset();
        step(3 * TD);
        chk("t6_no_late_finish", finish, 0);

        // Random traffic
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) run = ~run;
            if ($urandom_range(0, 3) == 0) btn = 2'($urandom);
            if ($urandom_range(0, 9) == 0) sel = 2'($urandom);
            step(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
